// File: rtl/upi_pay_gateway.sv
// ============================================================================
// Module   : upi_pay_gateway
// Purpose  : UPI payment responder for the vending controller. It accepts a
//            priced request, shows a QR prompt, and waits for a bank credit.
//            Bad credits are retried, and timeout and cancel are enforced.
//            The optional overpayment refund is built with OVERPAY_REFUND_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module upi_pay_gateway #(
  parameter int AMT_W          = 8,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int MAX_RETRY      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pay_req,
  input  logic [AMT_W-1:0] amount,
  input  logic             cancel,
  input  logic             bank_ack_valid,
  input  logic             bank_ack_ok,
  input  logic [AMT_W-1:0] bank_ack_amt,
  output logic             qr_valid,
  output logic [AMT_W-1:0] qr_amount,
  output logic             busy,
  output logic             pay_done,
  output logic             pay_fail,
  output logic [1:0]       fail_code,
  output logic [7:0]       txn_id
`ifdef OVERPAY_REFUND_EN
  ,
  output logic             refund_valid,
  output logic [AMT_W-1:0] refund_amt
`endif
);

  localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(MAX_RETRY);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;
  localparam logic [1:0] c_FAIL = 2'd3;

  localparam logic [1:0] c_CODE_NONE    = 2'd0;
  localparam logic [1:0] c_CODE_TIMEOUT = 2'd1;
  localparam logic [1:0] c_CODE_RETRY   = 2'd2;
  localparam logic [1:0] c_CODE_CANCEL  = 2'd3;

  logic [1:0]         r_state;
  logic               r_pay_req_q;
  logic [AMT_W-1:0]   r_amt;
  logic [c_TMR_W-1:0] r_timer;
  logic [c_RTY_W-1:0] r_retry;
  logic [1:0]         r_fail_code;
  logic [7:0]         r_txn_id;

  logic w_accept;
  logic w_ack_good;

  assign w_accept = pay_req & ~r_pay_req_q & (r_state == c_IDLE);

`ifdef OVERPAY_REFUND_EN
  logic [AMT_W-1:0] r_refund_amt;

  // Overpayment still completes the sale; the excess is reported as a refund.
  assign w_ack_good = bank_ack_valid & bank_ack_ok & (bank_ack_amt >= r_amt);
`else
  assign w_ack_good = bank_ack_valid & bank_ack_ok & (bank_ack_amt == r_amt);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_pay_req_q <= 1'b0;
      r_amt       <= '0;
      r_timer     <= '0;
      r_retry     <= '0;
      r_fail_code <= c_CODE_NONE;
      r_txn_id    <= 8'd0;
`ifdef OVERPAY_REFUND_EN
      r_refund_amt <= '0;
`endif
    end else begin
      // Edge register tracks pay_req in every state so a held level never retriggers.
      r_pay_req_q <= pay_req;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_txn_id <= r_txn_id + 8'd1;
`ifdef OVERPAY_REFUND_EN
            r_refund_amt <= '0;
`endif
            if (amount != '0) begin
              r_amt       <= amount;
              r_timer     <= '0;
              r_retry     <= '0;
              r_fail_code <= c_CODE_NONE;
              r_state     <= c_WAIT;
            end else begin
              r_fail_code <= c_CODE_CANCEL;
              r_state     <= c_FAIL;
            end
          end
        end
        c_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (w_ack_good) begin
`ifdef OVERPAY_REFUND_EN
            r_refund_amt <= bank_ack_amt - r_amt;
`endif
            r_state <= c_DONE;
          end else if (cancel) begin
            r_fail_code <= c_CODE_CANCEL;
            r_state     <= c_FAIL;
          end else if (bank_ack_valid) begin
            if (r_retry == c_RTY_MAX) begin
              r_fail_code <= c_CODE_RETRY;
              r_state     <= c_FAIL;
            end else begin
              r_retry <= r_retry + 1'b1;
              r_timer <= '0;
            end
          end else if (r_timer == c_TMR_LAST) begin
            r_fail_code <= c_CODE_TIMEOUT;
            r_state     <= c_FAIL;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != c_IDLE);
  assign qr_valid  = (r_state == c_WAIT);
  assign qr_amount = qr_valid ? r_amt : '0;
  assign pay_done  = (r_state == c_DONE);
  assign pay_fail  = (r_state == c_FAIL);
  assign fail_code = r_fail_code;
  assign txn_id    = r_txn_id;

`ifdef OVERPAY_REFUND_EN
  assign refund_valid = pay_done & (r_refund_amt != '0);
  assign refund_amt   = r_refund_amt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_upi_pay_gateway.sv
// ============================================================================
// Module   : tb_upi_pay_gateway
// Purpose  : Self-checking bench for upi_pay_gateway: vector table plus
//            hand-written corner sequences, with a response scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_upi_pay_gateway;

  localparam int AMT_W     = 8;
  localparam int MAX_RETRY = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pay_req = 1'b0;
  logic [AMT_W-1:0] amount = '0;
  logic             cancel = 1'b0;
  logic             bank_ack_valid = 1'b0;
  logic             bank_ack_ok = 1'b0;
  logic [AMT_W-1:0] bank_ack_amt = '0;
  logic             qr_valid;
  logic [AMT_W-1:0] qr_amount;
  logic             busy;
  logic             pay_done;
  logic             pay_fail;
  logic [1:0]       fail_code;
  logic [7:0]       txn_id;
`ifdef OVERPAY_REFUND_EN
  logic             refund_valid;
  logic [AMT_W-1:0] refund_amt;
`endif

  upi_pay_gateway #(.AMT_W(AMT_W), .TIMEOUT_CYCLES(200), .MAX_RETRY(MAX_RETRY)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pay_req        (pay_req),
    .amount         (amount),
    .cancel         (cancel),
    .bank_ack_valid (bank_ack_valid),
    .bank_ack_ok    (bank_ack_ok),
    .bank_ack_amt   (bank_ack_amt),
    .qr_valid       (qr_valid),
    .qr_amount      (qr_amount),
    .busy           (busy),
    .pay_done       (pay_done),
    .pay_fail       (pay_fail),
    .fail_code      (fail_code),
    .txn_id         (txn_id)
`ifdef OVERPAY_REFUND_EN
    ,
    .refund_valid   (refund_valid),
    .refund_amt     (refund_amt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       done;
    logic [1:0] code;
    logic [7:0] id;
  } exp_t;

  typedef struct {
    logic [7:0] amount;
    int         n_bad;
    logic       bad_ok;
    logic [7:0] bad_amt;
    int         gap;
    bit         good;
    bit         cxl;
    logic       exp_done;
    logic [1:0] exp_code;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_id  = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic done, input logic [1:0] code);
    exp_t e;
    exp_id = exp_id + 8'd1;
    e.done = done;
    e.code = code;
    e.id   = exp_id;
    sb.push_back(e);
  endtask

  task automatic add_vec(input logic [7:0] amt, input int n_bad, input logic bad_ok,
                         input logic [7:0] bad_amt, input int gap, input bit good,
                         input bit cxl, input logic exp_done, input logic [1:0] exp_code);
    vec_t v;
    v.amount = amt;  v.n_bad = n_bad;  v.bad_ok = bad_ok;  v.bad_amt = bad_amt;
    v.gap = gap;     v.good = good;    v.cxl = cxl;
    v.exp_done = exp_done;  v.exp_code = exp_code;
    vecs.push_back(v);
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while ((sb.size() != 0 || busy) && i < 400) begin
      step();
      i++;
    end
    check({name, "_pending"}, sb.size(), 0);
  endtask

  task automatic bank_ack(input logic ok, input logic [7:0] amt, input logic cxl);
    bank_ack_valid = 1'b1;
    bank_ack_ok    = ok;
    bank_ack_amt   = amt;
    cancel         = cxl;
    step();
    bank_ack_valid = 1'b0;
    bank_ack_ok    = 1'b0;
    bank_ack_amt   = '0;
    cancel         = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    amount  = v.amount;
    pay_req = 1'b1;
    push_exp(v.exp_done, v.exp_code);
    step();
    if (v.amount != 8'd0) begin
      check({p, "_qr_valid"}, qr_valid, 1);
      check({p, "_qr_amount"}, qr_amount, v.amount);
      check({p, "_busy"}, busy, 1);
      for (int b = 0; b < v.n_bad; b++) begin
        step(v.gap);
        bank_ack(v.bad_ok, v.bad_amt, 1'b0);
        if (b < MAX_RETRY) check($sformatf("%s_retry%0d_stay", p, b), qr_valid, 1);
        else               check({p, "_retry_exhaust"}, pay_fail, 1);
      end
      if (v.good) begin
        step(v.gap);
        bank_ack(1'b1, v.amount, v.cxl);
        check({p, "_done_latency"}, pay_done, 1);
        check({p, "_no_fail"}, pay_fail, 0);
      end else if (v.cxl) begin
        step(v.gap);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check({p, "_cancel_fail"}, pay_fail, 1);
      end
    end
    wait_idle(p);
    check({p, "_code_held"}, fail_code, v.exp_code);
    check({p, "_txn_id"}, txn_id, exp_id);
    pay_req = 1'b0;
    step();
  endtask

  // Scoreboard consumer: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (pay_done || pay_fail)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, pay_done, pay_fail}, 0);
      end else begin
        e = sb.pop_front();
        check("resp_done", pay_done, e.done);
        check("resp_fail", pay_fail, !e.done);
        check("resp_code", fail_code, e.code);
        check("resp_txn_id", txn_id, e.id);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    add_vec(8'd23,  0, 1'b0, 8'd0,   4, 1'b1, 1'b0, 1'b1, 2'd0); // happy path
    add_vec(8'd23,  3, 1'b1, 8'd22,  2, 1'b0, 1'b0, 1'b0, 2'd2); // retries exhausted
    add_vec(8'd23,  2, 1'b0, 8'd23,  1, 1'b1, 1'b0, 1'b1, 2'd0); // ok=0 twice then good
    add_vec(8'd23,  0, 1'b0, 8'd0,   3, 1'b1, 1'b1, 1'b1, 2'd0); // good ack beats cancel
    add_vec(8'd23,  0, 1'b0, 8'd0,   3, 1'b0, 1'b1, 1'b0, 2'd3); // cancel alone
    add_vec(8'd0,   0, 1'b0, 8'd0,   0, 1'b0, 1'b0, 1'b0, 2'd3); // zero amount
    add_vec(8'd255, 1, 1'b1, 8'd254, 0, 1'b1, 1'b0, 1'b1, 2'd0); // max price, ack at once
    add_vec(8'd1,   0, 1'b0, 8'd0,  10, 1'b1, 1'b0, 1'b1, 2'd0); // min price
`ifndef OVERPAY_REFUND_EN
    add_vec(8'd23,  1, 1'b1, 8'd30,  2, 1'b1, 1'b0, 1'b1, 2'd0); // overpay -> retry path
`endif

    step(3);
    check("rst_qr_valid", qr_valid, 0);
    check("rst_qr_amount", qr_amount, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {pay_done, pay_fail}, 0);
    check("rst_fail_code", fail_code, 0);
    check("rst_txn_id", txn_id, 0);
`ifdef OVERPAY_REFUND_EN
    check("rst_refund", {refund_valid, refund_amt}, 0);
`endif
    rst_n = 1'b1;
    step(2);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Exact timeout: 200 WAIT cycles, FAIL on the 201st.
    amount = 8'd40;  pay_req = 1'b1;  push_exp(1'b0, 2'd1);
    step();
    step(199);
    check("tmo_still_wait", qr_valid, 1);
    check("tmo_no_early_fail", pay_fail, 0);
    step();
    check("tmo_fail", pay_fail, 1);
    check("tmo_qr_drop", qr_valid, 0);
    check("tmo_code", fail_code, 1);
    wait_idle("tmo");
    pay_req = 1'b0;  step();

    // A bad ack restarts the timeout window.
    amount = 8'd9;  pay_req = 1'b1;  push_exp(1'b0, 2'd1);
    step();
    step(150);
    bank_ack(1'b1, 8'd8, 1'b0);
    step(199);
    check("rtmr_still_wait", qr_valid, 1);
    step();
    check("rtmr_fail", pay_fail, 1);
    wait_idle("rtmr");
    pay_req = 1'b0;  step();

    // Held pay_req: no retrigger; stray ack/cancel in IDLE are ignored.
    amount = 8'd23;  pay_req = 1'b1;  push_exp(1'b1, 2'd0);
    step(3);
    bank_ack(1'b1, 8'd23, 1'b0);
    check("held_done", pay_done, 1);
    step(6);
    bank_ack(1'b1, 8'd23, 1'b1);
    check("held_no_retrigger", busy, 0);
    check("held_txn_id", txn_id, exp_id);
    pay_req = 1'b0;  step();

    // Reset mid-transaction: outputs clear immediately, no pulse.
    amount = 8'd50;  pay_req = 1'b1;
    step();
    check("rmid_qr_valid", qr_valid, 1);
    step(3);
    rst_n = 1'b0;
    #1;
    check("rmid_qr_valid_clr", qr_valid, 0);
    check("rmid_qr_amount_clr", qr_amount, 0);
    check("rmid_busy_clr", busy, 0);
    check("rmid_pulses_clr", {pay_done, pay_fail}, 0);
    check("rmid_txn_id_clr", txn_id, 0);
    exp_id = 8'd0;
    step(2);
    pay_req = 1'b0;
    rst_n   = 1'b1;
    step(5);
    check("rmid_idle_after", busy, 0);

`ifdef OVERPAY_REFUND_EN
    amount = 8'd23;  pay_req = 1'b1;  push_exp(1'b1, 2'd0);
    step(3);
    bank_ack(1'b1, 8'd30, 1'b0);
    check("ovp_done", pay_done, 1);
    check("ovp_refund_valid", refund_valid, 1);
    check("ovp_refund_amt", refund_amt, 7);
    wait_idle("ovp");
    check("ovp_refund_held", refund_amt, 7);
    check("ovp_refund_pulse_end", refund_valid, 0);
    pay_req = 1'b0;  step();
    amount = 8'd23;  pay_req = 1'b1;  push_exp(1'b1, 2'd0);
    step(2);
    bank_ack(1'b1, 8'd23, 1'b0);
    check("exact_done", pay_done, 1);
    check("exact_refund", {refund_valid, refund_amt}, 0);
    wait_idle("exact");
    pay_req = 1'b0;  step();
`endif

    step(2);
    check("scoreboard_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/upi_pay_gateway.md
Name: upi_pay_gateway

Overview:
UPI payment responder on the far side of the vending controller's upi_pay_req/upi_pay_done handshake. It accepts a payment request with a price, shows a QR prompt, and waits for bank confirmation. It checks the credited amount, retries on a bad credit, and enforces a timeout and cancel. It returns a one-cycle pay_done or pay_fail pulse to the controller.

Parameters:
AMT_W, 8, width of amount fields (matches controller price width)
TIMEOUT_CYCLES, 200, cycles to wait in WAIT_BANK per attempt before failing
MAX_RETRY, 2, bad bank credits tolerated before failing (a failure occurs on bad ack number MAX_RETRY+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pay_req  in  1  payment request from vending controller; level, rising edge starts a transaction
amount  in  AMT_W  price to collect; sampled on accepted pay_req edge
cancel  in  1  user/controller abort
bank_ack_valid  in  1  bank response strobe, one cycle
bank_ack_ok  in  1  bank reports credit success (qualified by bank_ack_valid)
bank_ack_amt  in  AMT_W  amount credited (qualified by bank_ack_valid)
qr_valid  out  1  QR/prompt display active
qr_amount  out  AMT_W  amount shown on QR (latched price)
busy  out  1  transaction in progress
pay_done  out  1  one-cycle success pulse to controller
pay_fail  out  1  one-cycle failure pulse
fail_code  out  2  0 none, 1 timeout, 2 retries exhausted, 3 cancel/zero amount; held until next accept
txn_id  out  8  transaction counter, increments on each accepted request, wraps 255->0

Behaviour:
- Reset (async, any state): state=IDLE.
- Reset values: all outputs 0, timer=0, retry_cnt=0, pay_req edge register=0.
- Reset mid-transaction aborts silently: no pay_fail pulse.
- Edge detect: pay_req_q is registered each cycle; accept = pay_req & ~pay_req_q while in IDLE. A level held high across completion never retriggers.
- States: IDLE, WAIT_BANK, DONE, FAIL. State is registered; all outputs decode from registered state and registers.
- IDLE: busy=0.
  - On accept with amount!=0: latch amt_r=amount, txn_id+1, timer=0, retry_cnt=0, fail_code=0; go to WAIT_BANK next cycle.
  - On accept with amount==0: fail_code=3, txn_id+1; go to FAIL.
- WAIT_BANK: busy=1, qr_valid=1, qr_amount=amt_r. Timer increments every cycle.
  - Priority 1: bank_ack_valid & bank_ack_ok & bank_ack_amt==amt_r -> DONE. Good payment beats simultaneous cancel or timeout.
  - Priority 2: cancel -> FAIL, fail_code=3.
  - Priority 3: bank_ack_valid that is not a good payment (ok=0 or amount mismatch):
    - if retry_cnt==MAX_RETRY -> FAIL, fail_code=2;
    - else retry_cnt+1, timer=0, stay in WAIT_BANK.
  - Priority 4: timer==TIMEOUT_CYCLES-1 -> FAIL, fail_code=1.
- DONE: pay_done=1, busy=1 for exactly one cycle -> IDLE.
- FAIL: pay_fail=1, busy=1 for exactly one cycle -> IDLE.
- Latency: accept edge at cycle N -> qr_valid at N+1. Good ack at cycle M -> pay_done at M+1.
- Timer width: clog2(TIMEOUT_CYCLES+1).
- Amount comparison: unsigned AMT_W equality, no truncation.
- bank_ack_valid in IDLE/DONE/FAIL is ignored. cancel outside WAIT_BANK is ignored.
- pay_req edge during DONE/FAIL is not accepted (edge register still updates).

Optional Feature:
- Macro: OVERPAY_REFUND_EN.
- Defined: adds outputs refund_valid (1) and refund_amt (AMT_W).
  - A bank ack with ok=1 and bank_ack_amt > amt_r is a good payment.
  - refund_amt = bank_ack_amt - amt_r is latched; refund_valid pulses coincident with pay_done.
  - Exact payment gives refund_amt=0, refund_valid=0.
  - refund_amt resets to 0 and holds until the next accept.
- Undefined: ports absent; overpayment is treated as a mismatch (retry path).

Test Plan:
- Happy path: pay_req rises, amount=8'd23; bank ack ok, amt=23 at 5 cycles later -> qr_amount=23 one cycle after edge; pay_done pulse 1 cycle after ack; txn_id=1; fail_code=0.
- Retry exhaustion (MAX_RETRY=2): three acks with amt=22 -> first two keep WAIT_BANK with timer reset; third -> pay_fail, fail_code=2.
- Timeout: no ack for 200 cycles after entering WAIT_BANK -> pay_fail on cycle 201, fail_code=1, qr_valid drops.
- Simultaneous cancel and good ack (amt=23) in the same cycle -> pay_done, no pay_fail. Cancel alone -> fail_code=3. amount=0 request -> immediate pay_fail, fail_code=3.
- Held pay_req and reset: pay_req held high through pay_done -> no second transaction until pay_req falls and rises again. rst_n asserted mid-WAIT_BANK -> all outputs 0 at once, no pulse.
- OVERPAY_REFUND_EN: amt_r=23, ack amt=30 -> pay_done with refund_valid=1, refund_amt=7. Without the macro, the same stimulus -> retry path.
